// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and default sizes for the memory fill engine
package mem_ctrl_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_STALL_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fill_datapath.sv
// rtl/fill_datapath.sv - fill address/data/remaining/stall counters for the fill engine
module fill_datapath #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int STALL_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              stall_inc,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] pattern,
    input  logic              incr_mode,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [DATA_W-1:0] cur_data,
    output logic              last_word,
    output logic              stall_full
);

    localparam int SW = $clog2(STALL_MAX + 1);

    logic [ADDR_W:0] remaining;
    logic [SW-1:0]   stall_cnt;
    logic            mode;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_addr  <= '0;
            cur_data  <= '0;
            remaining <= '0;
            stall_cnt <= '0;
            mode      <= 1'b0;
        end else if (load) begin
            cur_addr  <= base_addr;
            cur_data  <= pattern;
            remaining <= length;
            stall_cnt <= '0;
            mode      <= incr_mode;
        end else if (step) begin
            // address and data both wrap naturally at their register widths
            cur_addr  <= cur_addr + ADDR_W'(1);
            cur_data  <= cur_data + {{(DATA_W-1){1'b0}}, mode};
            remaining <= remaining - (ADDR_W+1)'(1);
            stall_cnt <= '0;
        end else if (stall_inc) begin
            stall_cnt <= stall_cnt + SW'(1);
        end
    end

    assign last_word  = (remaining == (ADDR_W+1)'(1));
    assign stall_full = (stall_cnt == SW'(STALL_MAX));

endmodule

// File: rtl/mem_fill_arbiter.sv
// rtl/mem_fill_arbiter.sv - memory fill sequencer sharing one port with a prioritised host
module mem_fill_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int STALL_MAX = DEF_STALL_MAX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] pattern,
    input  logic              incr_mode,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done
);

    fill_state_t       state, state_next;
    logic              load, step, stall_inc, gnt_int;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              last_word, stall_full;

    fill_datapath #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STALL_MAX (STALL_MAX)
    ) u_datapath (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .stall_inc  (stall_inc),
        .base_addr  (base_addr),
        .length     (length),
        .pattern    (pattern),
        .incr_mode  (incr_mode),
        .cur_addr   (cur_addr),
        .cur_data   (cur_data),
        .last_word  (last_word),
        .stall_full (stall_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        stall_inc  = 1'b0;
        gnt_int    = 1'b0;
        case (state)
            IDLE: begin
                gnt_int = host_req;
                if (start) begin
                    state_next = (length != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                gnt_int = host_req;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    load       = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // abort suppresses the engine write; the host may still use the port
                if (abort) begin
                    gnt_int    = host_req;
                    state_next = IDLE;
                end else if (!host_req || stall_full) begin
                    step = 1'b1;
                    if (last_word) begin
                        state_next = DONE;
                    end
                end else begin
                    gnt_int   = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            DONE: begin
                gnt_int    = host_req;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (step) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = cur_data;
            end else if (gnt_int) begin
                mem_en    = 1'b1;
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
        end
    end

    assign host_gnt = gnt_int && !reset;
    assign busy     = !reset && ((state == LOAD) || (state == WRITE));
    assign done     = !reset && (state == DONE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb/tb_mem_fill_arbiter.sv - self-checking bench for mem_fill_arbiter
module tb_mem_fill_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SM = 4;

    logic          clock, reset, start, abort, incr_mode;
    logic [AW-1:0] base_addr, host_addr, mem_addr;
    logic [AW:0]   length;
    logic [DW-1:0] pattern, host_wdata, mem_wdata;
    logic          host_req, host_we, host_gnt, mem_en, mem_we, busy, done;

    mem_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STALL_MAX(SM)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .pattern(pattern), .incr_mode(incr_mode),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            n_done, done_cyc, busy_cyc, arb_err, route_err, idle_err;
    logic          busy_after_abort;

    // Drives one fill and records what the port did; expectations are checked by callers.
    task automatic do_fill(input logic [AW-1:0] b, input logic [AW:0] l, input logic [DW-1:0] p,
                           input logic inc, input int host_pct, input int abort_cyc);
        int   consec, stop_at, nw;
        logic exp_eng, eng_obs;
        bit   in_write, aborted;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        n_done = 0; done_cyc = -1; busy_cyc = 0; arb_err = 0; route_err = 0; idle_err = 0;
        busy_after_abort = 1'bx; consec = 0; stop_at = -1; aborted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            start = (cyc == 0); base_addr = b; length = l; pattern = p; incr_mode = inc;
            abort = (cyc == abort_cyc);
            host_req = (host_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < host_pct);
            host_we = 1'($urandom); host_addr = AW'($urandom); host_wdata = DW'($urandom);
            #1;
            nw = wr_cyc.size();
            in_write = (cyc >= 2) && (nw < int'(l)) && !aborted;
            eng_obs = mem_en && !host_gnt;
            if (busy) busy_cyc++;
            if (done) begin n_done++; done_cyc = cyc; end
            if (host_gnt && (!mem_en || mem_we !== host_we || mem_addr !== host_addr || mem_wdata !== host_wdata))
                route_err++;
            if (!mem_en && (mem_we || mem_addr != '0 || mem_wdata != '0)) idle_err++;
            if (eng_obs) begin
                if (!mem_we) route_err++;
                wr_cyc.push_back(cyc); wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata);
            end
            if (in_write && cyc == abort_cyc) begin
                if (eng_obs) arb_err++;
            end else if (in_write) begin
                exp_eng = !host_req || (consec == SM);
                if (eng_obs !== exp_eng || host_gnt !== (host_req && !exp_eng)) arb_err++;
                consec = exp_eng ? 0 : consec + 1;
            end else if (host_gnt !== host_req) begin
                arb_err++;
            end
            if (cyc == abort_cyc) aborted = 1;
            if (cyc == abort_cyc + 1) busy_after_abort = busy;
            if (done && stop_at < 0) stop_at = cyc + 1;
            if (abort_cyc >= 0 && cyc == abort_cyc + 2) break;
            if (cyc == stop_at) break;
        end
        @(negedge clock);
        start = 1'b0; abort = 1'b0; host_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 8'h55; host_wdata = 16'h1234;
        #1;
        total++; if (host_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b want=0", host_gnt); end
        total++; if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL reset_en got=%b want=00", {mem_en, mem_we}); end
        total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL reset_bus got=%h/%h want=0/0", mem_addr, mem_wdata); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", {busy, done}); end
        @(negedge clock);
        reset = 1'b0; host_req = 1'b0;
        #1;
        total++; if ({mem_en, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_release got=%b want=000", {mem_en, busy, done}); end
    endtask

    task automatic test_incr_fill();
        do_fill(8'h10, 9'd4, 16'hA000, 1'b1, 0, -1);
        total++; if (wr_cyc.size() !== 4) begin bad++; $display("FAIL incr_count got=%0d want=4", wr_cyc.size()); end
        for (int i = 0; i < wr_cyc.size() && i < 4; i++) begin
            total++;
            if (wr_addr[i] !== 8'h10 + 8'(i) || wr_data[i] !== 16'hA000 + 16'(i) || wr_cyc[i] !== 2 + i) begin
                bad++; $display("FAIL incr_word%0d got=%h/%h@%0d want=%h/%h@%0d", i, wr_addr[i], wr_data[i], wr_cyc[i],
                                8'h10 + 8'(i), 16'hA000 + 16'(i), 2 + i);
            end
        end
        total++; if (n_done !== 1 || done_cyc !== 6) begin bad++; $display("FAIL incr_done got=%0d@%0d want=1@6", n_done, done_cyc); end
        total++; if (busy_cyc !== 5) begin bad++; $display("FAIL incr_busy got=%0d want=5", busy_cyc); end
        total++; if (arb_err + route_err + idle_err !== 0) begin bad++; $display("FAIL incr_port got=%0d/%0d/%0d want=0", arb_err, route_err, idle_err); end
    endtask

    task automatic test_wrap_const();
        logic [AW-1:0] exp_a[4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        do_fill(8'hFE, 9'd4, 16'h5A5A, 1'b0, 0, -1);
        total++; if (wr_cyc.size() !== 4) begin bad++; $display("FAIL wrap_count got=%0d want=4", wr_cyc.size()); end
        for (int i = 0; i < wr_cyc.size() && i < 4; i++) begin
            total++;
            if (wr_addr[i] !== exp_a[i] || wr_data[i] !== 16'h5A5A) begin
                bad++; $display("FAIL wrap_word%0d got=%h/%h want=%h/5a5a", i, wr_addr[i], wr_data[i], exp_a[i]);
            end
        end
        total++; if (n_done !== 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", n_done); end
    endtask

    task automatic test_zero_length();
        do_fill(8'h33, 9'd0, 16'hFFFF, 1'b1, 0, -1);
        total++; if (wr_cyc.size() !== 0) begin bad++; $display("FAIL zero_writes got=%0d want=0", wr_cyc.size()); end
        total++; if (n_done !== 1 || done_cyc !== 1) begin bad++; $display("FAIL zero_done got=%0d@%0d want=1@1", n_done, done_cyc); end
        total++; if (busy_cyc !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", busy_cyc); end
    endtask

    task automatic test_host_stall();
        do_fill(8'h40, 9'd3, 16'h0100, 1'b1, 100, -1);
        total++; if (wr_cyc.size() !== 3) begin bad++; $display("FAIL stall_count got=%0d want=3", wr_cyc.size()); end
        for (int i = 0; i < wr_cyc.size() && i < 3; i++) begin
            total++;
            if (wr_cyc[i] !== 2 + SM + i * (SM + 1) || wr_data[i] !== 16'h0100 + 16'(i)) begin
                bad++; $display("FAIL stall_word%0d got=%h@%0d want=%h@%0d", i, wr_data[i], wr_cyc[i],
                                16'h0100 + 16'(i), 2 + SM + i * (SM + 1));
            end
        end
        total++; if (n_done !== 1) begin bad++; $display("FAIL stall_done got=%0d want=1", n_done); end
        total++; if (arb_err + route_err !== 0) begin bad++; $display("FAIL stall_arb got=%0d/%0d want=0", arb_err, route_err); end
    endtask

    task automatic test_abort();
        do_fill(8'h80, 9'd8, 16'h7000, 1'b1, 0, 4);
        total++; if (wr_cyc.size() !== 2) begin bad++; $display("FAIL abort_writes got=%0d want=2", wr_cyc.size()); end
        total++; if (n_done !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", n_done); end
        total++; if (busy_after_abort !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy_after_abort); end
        total++; if (arb_err !== 0) begin bad++; $display("FAIL abort_arb got=%0d want=0", arb_err); end
        do_fill(8'h90, 9'd3, 16'h0001, 1'b1, 0, -1);
        total++; if (wr_cyc.size() !== 3 || n_done !== 1) begin bad++; $display("FAIL abort_restart got=%0d/%0d want=3/1", wr_cyc.size(), n_done); end
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        logic [AW:0]   l;
        logic [DW-1:0] p;
        logic          inc;
        int            errs;
        for (int it = 0; it < 6; it++) begin
            b = AW'($urandom); p = DW'($urandom); inc = 1'($urandom);
            l = (it == 0) ? 9'd256 : 9'($urandom_range(1, 20));
            do_fill(b, l, p, inc, $urandom_range(0, 90), -1);
            total++; if (wr_cyc.size() !== int'(l)) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", it, wr_cyc.size(), l); end
            errs = 0;
            for (int i = 0; i < wr_cyc.size(); i++)
                if (wr_addr[i] !== b + AW'(i) || wr_data[i] !== p + DW'(i) * DW'(inc)) errs++;
            total++; if (errs !== 0) begin bad++; $display("FAIL rand%0d_words got=%0d bad words want=0", it, errs); end
            total++; if (n_done !== 1 || wr_cyc.size() == 0 || done_cyc !== wr_cyc[$] + 1) begin
                bad++; $display("FAIL rand%0d_done got=%0d@%0d want=1 after last write", it, n_done, done_cyc); end
            total++; if (arb_err + route_err + idle_err !== 0) begin
                bad++; $display("FAIL rand%0d_port got=%0d/%0d/%0d want=0", it, arb_err, route_err, idle_err); end
        end
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clock);
        start = 1'b1; base_addr = 8'h20; length = 9'd10; pattern = 16'hC000; incr_mode = 1'b1; host_req = 1'b0;
        repeat (4) begin @(negedge clock); start = 1'b0; end
        reset = 1'b1; host_req = 1'b1;
        #1;
        total++; if ({host_gnt, mem_en, mem_we, busy, done} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL midreset_outs got=%b %h %h want=0", {host_gnt, mem_en, mem_we, busy, done}, mem_addr, mem_wdata); end
        @(negedge clock);
        reset = 1'b0; host_req = 1'b0;
        #1;
        total++; if ({mem_en, busy, done} !== 3'b000) begin bad++; $display("FAIL midreset_idle got=%b want=000", {mem_en, busy, done}); end
        @(negedge clock);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h21; host_wdata = 16'h0;
        #1;
        total++; if (host_gnt !== 1'b1 || mem_addr !== 8'h21 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_host got=%b/%h/%b want=1/21/0", host_gnt, mem_addr, busy); end
        @(negedge clock);
        host_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0; pattern = '0;
        incr_mode = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_incr_fill();
        test_wrap_const();
        test_zero_length();
        test_host_stall();
        test_abort();
        test_random();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
Sequences a single-port memory fill: writes a fixed or incrementing pattern over a region [base, base+length-1] on start, with busy/done handshake.
Shares the same memory port with a host requester. The host has priority, limited by a starvation guard that forces engine progress.
Sits between the host bus logic and the memory macro, upstream of the zero/init datapath.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 16, memory data width
STALL_MAX, 4, max consecutive host grants while the engine is writing before the engine takes one cycle (>=1)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin fill; sampled in IDLE only
abort  in  1  cancel fill in progress
base_addr  in  ADDR_W  first fill address
length  in  ADDR_W+1  word count, 0..2^ADDR_W
pattern  in  DATA_W  first data word
incr_mode  in  1  1: data increments by 1 per word written; 0: constant
host_req  in  1  host wants the port this cycle
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host owns the port this cycle
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
busy  out  1  fill in progress (LOAD or WRITE)
done  out  1  one-cycle pulse on fill completion

Behaviour:
- Clock is clock; reset is reset: synchronous, active-high.
- Reset: state IDLE. busy=0, done=0, host_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 while reset is high. Internal counters cleared.
- States: IDLE, LOAD, WRITE, DONE (enum in package).
- IDLE:
  - start with length!=0 -> LOAD.
  - start with length==0 -> DONE; no memory write occurs.
- LOAD:
  - Latch cur_addr=base_addr, remaining=length, cur_data=pattern, mode=incr_mode. busy=1. -> WRITE.
- WRITE, busy=1:
  - Engine cycle when (host_req==0) or (stall_cnt==STALL_MAX).
  - On an engine cycle: mem_en=1, mem_we=1, mem_addr=cur_addr, mem_wdata=cur_data, host_gnt=0. Then cur_addr+=1 (wraps), cur_data+=mode (wraps modulo 2^DATA_W), remaining-=1, stall_cnt=0.
  - If remaining==1 on an engine cycle -> DONE.
  - Otherwise, on a host cycle: host_gnt=1, counters hold, stall_cnt+=1.
- Host routing: when host_gnt=1, mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
- host_gnt is combinational from host_req and state. It is always host_req in IDLE, LOAD and DONE. Zero-cycle grant latency.
- DONE: done=1 for exactly one cycle, busy=0. -> IDLE.
- abort in LOAD or WRITE:
  - Takes precedence over the engine write that cycle, so no engine write occurs.
  - -> IDLE next cycle; done is not pulsed.
  - Words already written stay written.
  - abort in IDLE or DONE is ignored.
- start while not IDLE is ignored. start and abort together in IDLE: start wins.
- Reset mid-fill: IDLE immediately; no further writes.
- Idle port: mem_en=0, mem_we=0, mem_addr/mem_wdata=0 when neither engine nor host drives.
- length=2^ADDR_W fills the whole memory once, ending at address base-1.

Decomposition:
- Package mem_ctrl_pkg: fill_state_t enum {IDLE, LOAD, WRITE, DONE}, default ADDR_W/DATA_W constants.
- Sub-module fill_datapath: cur_addr/remaining/cur_data/stall_cnt registers with load/step/clear controls, and the last-word flag.
- The top level holds the FSM and the output mux.

Test Plan:
- base=0x10, length=4, pattern=0xA000, incr=1, no host -> writes 0x10..0x13 with 0xA000..0xA003 on consecutive cycles. done pulses once, 1 cycle after the last write. busy high LOAD through the last write.
- base=0xFE, length=4, incr=0 -> addresses 0xFE, 0xFF, 0x00, 0x01, all data=pattern.
- length=0 start -> no mem_we, done pulse 1 cycle after start.
- host_req held high during WRITE with STALL_MAX=4 -> 4 host grants, then 1 engine write with host_gnt=0, repeating. Fill still completes.
- abort on the 3rd WRITE cycle of a length=8 fill -> exactly 2 engine writes, no done, busy=0 next cycle. A new start then works normally.
- reset asserted mid-fill and host_req during reset -> all outputs 0, host_gnt=0, FSM in IDLE after reset release.
